// File: rtl/tx_phyretrain.sv
// tx_phyretrain: transmit-side PHYRETRAIN handshake engine for the LTSM.
// Resolves the local retrain cause into a one-hot encoding and sends
// PHYRETRAIN_START_REQ over the sideband. It then waits for the partner's
// PHYRETRAIN_START_RESP and reports completion (or timeout) to the LTSM.
//
// Optional feature macro: PHYRETRAIN_TIMEOUT_EN
//   defined   -> response timeout counter, TIMEOUT state and o_timeout active
//   undefined -> no counter, o_timeout tied low, waits indefinitely for RESP
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_phyretrain_en              LTSM enable; low returns the block to IDLE
//   i_txselfcal_req              local cause: TX self-calibration
//   i_speedidle_req              local cause: speed change
//   i_repair_req                 local cause: lane repair
//   i_SB_Busy                    sideband transmitter busy
//   i_falling_edge_busy          pulse: sideband consumed current message
//   i_rx_valid                   RX PHYRETRAIN stage owns the sideband
//   i_rx_msg_valid               decoded partner message valid
//   i_decoded_SB_msg             decoded partner message ID
//   o_encoded_SB_msg_tx          message ID to sideband (1 = START_REQ)
//   o_local_retrain_encoding     latched cause (001/010/100), request payload
//   o_valid_tx                   TX message valid to sideband wrapper
//   o_phyretrain_end_tx          handshake complete
//   o_timeout                    response not received in time
module tx_phyretrain #(
  parameter int unsigned SB_MSG_WIDTH   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 8000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_phyretrain_en,
  input  logic                    i_txselfcal_req,
  input  logic                    i_speedidle_req,
  input  logic                    i_repair_req,
  input  logic                    i_SB_Busy,
  input  logic                    i_falling_edge_busy,
  input  logic                    i_rx_valid,
  input  logic                    i_rx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx,
  output logic [2:0]              o_local_retrain_encoding,
  output logic                    o_valid_tx,
  output logic                    o_phyretrain_end_tx,
  output logic                    o_timeout
);

  localparam logic [SB_MSG_WIDTH-1:0] MSG_REQ  = SB_MSG_WIDTH'(1);
  localparam logic [SB_MSG_WIDTH-1:0] MSG_RESP = SB_MSG_WIDTH'(2);

  localparam logic [2:0] ENC_TXSELFCAL = 3'b001;
  localparam logic [2:0] ENC_SPEEDIDLE = 3'b010;
  localparam logic [2:0] ENC_REPAIR    = 3'b100;

  // Parameter sanity: the timeout window needs at least two cycles.
  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("tx_phyretrain: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_REQ  = 3'd1,
    ST_WAIT_RESP = 3'd2,
    ST_DONE      = 3'd3,
    ST_TIMEOUT   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;
  logic [2:0]              enc_q, enc_d;
  logic                    valid_q, valid_d;
  logic                    valid_dly_q, valid_dly_d;
  logic                    pending_q, pending_d;
  logic                    resp_seen_q, resp_seen_d;
  logic                    end_q, end_d;
  logic                    resp_now;
  logic                    in_hs;
  logic [2:0]              cause_enc;

`ifdef PHYRETRAIN_TIMEOUT_EN
  localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             tmo_hit;
`endif

  // Cause priority: SPEEDIDLE > REPAIR > TXSELFCAL; no cause defaults to TXSELFCAL.
  always_comb begin
    if (i_speedidle_req) begin
      cause_enc = ENC_SPEEDIDLE;
    end else if (i_repair_req) begin
      cause_enc = ENC_REPAIR;
    end else if (i_txselfcal_req) begin
      cause_enc = ENC_TXSELFCAL;
    end else begin
      cause_enc = ENC_TXSELFCAL;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    msg_d       = msg_q;
    enc_d       = enc_q;
    valid_d     = valid_q;
    valid_dly_d = valid_q;
    pending_d   = pending_q;
    resp_seen_d = resp_seen_q;
    end_d       = (state_q == ST_DONE);

    resp_now = i_rx_msg_valid && (i_decoded_SB_msg == MSG_RESP);
    in_hs    = (state_q == ST_SEND_REQ) || (state_q == ST_WAIT_RESP);

`ifdef PHYRETRAIN_TIMEOUT_EN
    timeout_d = (state_q == ST_TIMEOUT);
    cnt_d     = '0;
    if (in_hs) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
    // Decision taken as the counter reaches its last value; a response wins.
    tmo_hit = in_hs && (cnt_d == CNT_MAX) && !resp_seen_q && !resp_now;
`endif

    // Early responses during SEND_REQ are remembered for WAIT_RESP.
    if (in_hs && resp_now) begin
      resp_seen_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        msg_d       = '0;
        valid_d     = 1'b0;
        pending_d   = 1'b0;
        resp_seen_d = 1'b0;
        if (i_phyretrain_en) begin
          state_d   = ST_SEND_REQ;
          pending_d = 1'b1;
          msg_d     = MSG_REQ;
          enc_d     = cause_enc;
        end
      end
      ST_SEND_REQ: begin
        // Falling edge of valid means the sideband took the request.
        if (valid_dly_q && !valid_q) begin
          state_d = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        if (resp_seen_q || resp_now) begin
          state_d = ST_DONE;
        end
      end
      default: begin
      end
    endcase

`ifdef PHYRETRAIN_TIMEOUT_EN
    if (tmo_hit) begin
      state_d = ST_TIMEOUT;
    end
`endif

    // Valid handshake: consumption clears valid and beats a new launch.
    if (state_q != ST_IDLE) begin
      if (i_falling_edge_busy) begin
        valid_d = 1'b0;
      end else if (pending_q && !i_SB_Busy && !i_rx_valid &&
                   (state_q == ST_SEND_REQ) && i_phyretrain_en) begin
        valid_d   = 1'b1;
        pending_d = 1'b0;
      end
    end

    if (!i_phyretrain_en) begin
      state_d = ST_IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      msg_q       <= '0;
      enc_q       <= '0;
      valid_q     <= 1'b0;
      valid_dly_q <= 1'b0;
      pending_q   <= 1'b0;
      resp_seen_q <= 1'b0;
      end_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      msg_q       <= msg_d;
      enc_q       <= enc_d;
      valid_q     <= valid_d;
      valid_dly_q <= valid_dly_d;
      pending_q   <= pending_d;
      resp_seen_q <= resp_seen_d;
      end_q       <= end_d;
    end
  end

`ifdef PHYRETRAIN_TIMEOUT_EN
  // Timeout counter and flag registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_encoded_SB_msg_tx      = msg_q;
  assign o_local_retrain_encoding = enc_q;
  assign o_valid_tx               = valid_q;
  assign o_phyretrain_end_tx      = end_q;

endmodule
